// File: rtl/rle_param_enc.sv
// rle_param_enc
//
// Run-length encoder. It reads a byte message from a single-port word
// memory, compresses it into (symbol, count) records, and writes the packed
// records back to the same memory. The count field is CNT_BYTES bytes wide
// and stored LSB first. Runs longer than the count maximum are split into
// several records. Byte order in every memory word is little-endian.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   start            begin a frame; sampled only in IDLE
//   message_addr     byte address of the input message (low 2 bits ignored)
//   message_size     input length in bytes
//   rle_addr         byte address of the output area (low 2 bits ignored)
//   rle_size         number of record bytes produced; valid while done=1
//   done             level, frame complete
//   port_A_*         memory port; addr/we/data_in are registered outputs,
//                    data_out returns read data one cycle after the address
module rle_param_enc #(
  parameter int CNT_BYTES = 1,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  input  logic [31:0]       rle_addr,
  output logic [31:0]       rle_size,
  output logic              done,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out
);

  localparam int              CW        = 8 * CNT_BYTES;
  localparam int              RW        = 8 + CW;
  localparam int              PW        = ADDR_W - 2;
  localparam logic [CW-1:0]   CNT_MAX   = '1;
  localparam logic [1:0]      REC_BYTES = 2'(1 + CNT_BYTES);

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_WAIT, S_CAP, S_SCAN, S_EMIT, S_WR, S_FLUSH, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   msg_ptr_q, msg_ptr_d;
  logic [PW-1:0]   out_ptr_q, out_ptr_d;
  logic [31:0]     bytes_left_q, bytes_left_d;
  logic [31:0]     word_q, word_d;
  logic            word_valid_q, word_valid_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic            have_run_q, have_run_d;
  logic [7:0]      run_sym_q, run_sym_d;
  logic [CW-1:0]   run_cnt_q, run_cnt_d;
  logic [RW-1:0]   stage_q, stage_d;
  logic [1:0]      stage_left_q, stage_left_d;
  logic            last_q, last_d;
  logic [31:0]     acc_q, acc_d;
  logic [2:0]      acc_cnt_q, acc_cnt_d;
  logic [31:0]     rle_size_q, rle_size_d;
  logic            done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;

  logic [31:0]     word_shifted;
  logic [7:0]      cur_byte;
  logic            unused_addr_bits;

  assign word_shifted     = word_q >> {byte_idx_q, 3'b000};
  assign cur_byte         = word_shifted[7:0];
  assign unused_addr_bits = ^{message_addr, rle_addr};

  assign port_A_clk     = clk;
  assign port_A_addr    = addr_q;
  assign port_A_we      = we_q;
  assign port_A_data_in = wdata_q;
  assign rle_size       = rle_size_q;
  assign done           = done_q;

  // Next-state logic. Memory write enable is a one-cycle pulse, so it
  // defaults low and is only raised by WR/FLUSH.
  always_comb begin
    state_d      = state_q;
    msg_ptr_d    = msg_ptr_q;
    out_ptr_d    = out_ptr_q;
    bytes_left_d = bytes_left_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    byte_idx_d   = byte_idx_q;
    have_run_d   = have_run_q;
    run_sym_d    = run_sym_q;
    run_cnt_d    = run_cnt_q;
    stage_d      = stage_q;
    stage_left_d = stage_left_q;
    last_d       = last_q;
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    rle_size_d   = rle_size_q;
    done_d       = done_q;
    addr_d       = addr_q;
    we_d         = 1'b0;
    wdata_d      = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          msg_ptr_d    = message_addr[ADDR_W-1:2];
          out_ptr_d    = rle_addr[ADDR_W-1:2];
          bytes_left_d = message_size;
          done_d       = 1'b0;
          rle_size_d   = 32'd0;
          have_run_d   = 1'b0;
          word_valid_d = 1'b0;
          byte_idx_d   = 2'd0;
          last_d       = 1'b0;
          acc_d        = 32'd0;
          acc_cnt_d    = 3'd0;
          stage_left_d = 2'd0;
          state_d      = (message_size == 32'd0) ? S_DONE : S_RD;
        end
      end

      S_RD: begin
        addr_d    = {msg_ptr_q, 2'b00};
        msg_ptr_d = msg_ptr_q + 1'b1;
        state_d   = S_WAIT;
      end

      S_WAIT: state_d = S_CAP;

      S_CAP: begin
        word_d       = port_A_data_out;
        word_valid_d = 1'b1;
        byte_idx_d   = 2'd0;
        state_d      = S_SCAN;
      end

      // Message exhausted: flush the open run as the final record.
      // Otherwise fetch a word if needed, or consume one byte.
      S_SCAN: begin
        if (bytes_left_q == 32'd0) begin
          stage_d      = {run_cnt_q, run_sym_q};
          stage_left_d = REC_BYTES;
          last_d       = 1'b1;
          state_d      = S_EMIT;
        end else if (!word_valid_q) begin
          state_d = S_RD;
        end else begin
          bytes_left_d = bytes_left_q - 32'd1;
          byte_idx_d   = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) word_valid_d = 1'b0;
          if (have_run_q && cur_byte == run_sym_q && run_cnt_q != CNT_MAX) begin
            run_cnt_d = run_cnt_q + 1'b1;
          end else begin
            if (have_run_q) begin
              stage_d      = {run_cnt_q, run_sym_q};
              stage_left_d = REC_BYTES;
              state_d      = S_EMIT;
            end
            run_sym_d  = cur_byte;
            run_cnt_d  = CW'(1);
            have_run_d = 1'b1;
          end
          // Skip the extra SCAN cycle when the word is used up and more
          // message remains; the final byte stays in SCAN to stage the record.
          if (state_d == S_SCAN && byte_idx_q == 2'd3 && bytes_left_q != 32'd1)
            state_d = S_RD;
        end
      end

      // Accumulator lanes above acc_cnt are always zero, so OR-in is enough.
      S_EMIT: begin
        acc_d        = acc_q | (32'(stage_q[7:0]) << {acc_cnt_q[1:0], 3'b000});
        stage_d      = stage_q >> 8;
        stage_left_d = stage_left_q - 2'd1;
        acc_cnt_d    = acc_cnt_q + 3'd1;
        rle_size_d   = rle_size_q + 32'd1;
        if (acc_cnt_q == 3'd3)
          state_d = S_WR;
        else if (stage_left_q == 2'd1)
          state_d = last_q ? S_FLUSH : S_SCAN;
        else
          state_d = S_EMIT;
      end

      S_WR: begin
        addr_d    = {out_ptr_q, 2'b00};
        we_d      = 1'b1;
        wdata_d   = acc_q;
        out_ptr_d = out_ptr_q + 1'b1;
        acc_d     = 32'd0;
        acc_cnt_d = 3'd0;
        if (stage_left_q != 2'd0)
          state_d = S_EMIT;
        else
          state_d = last_q ? S_FLUSH : S_SCAN;
      end

      S_FLUSH: begin
        if (acc_cnt_q != 3'd0) begin
          addr_d    = {out_ptr_q, 2'b00};
          we_d      = 1'b1;
          wdata_d   = acc_q;
          out_ptr_d = out_ptr_q + 1'b1;
          acc_d     = 32'd0;
          acc_cnt_d = 3'd0;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        done_d = 1'b1;
        if (start) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      msg_ptr_q    <= '0;
      out_ptr_q    <= '0;
      bytes_left_q <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      byte_idx_q   <= '0;
      have_run_q   <= 1'b0;
      run_sym_q    <= '0;
      run_cnt_q    <= '0;
      stage_q      <= '0;
      stage_left_q <= '0;
      last_q       <= 1'b0;
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      rle_size_q   <= '0;
      done_q       <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      msg_ptr_q    <= msg_ptr_d;
      out_ptr_q    <= out_ptr_d;
      bytes_left_q <= bytes_left_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      byte_idx_q   <= byte_idx_d;
      have_run_q   <= have_run_d;
      run_sym_q    <= run_sym_d;
      run_cnt_q    <= run_cnt_d;
      stage_q      <= stage_d;
      stage_left_q <= stage_left_d;
      last_q       <= last_d;
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      rle_size_q   <= rle_size_d;
      done_q       <= done_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_rle_param_enc.sv
// tb_rle_param_enc
//
// Testbench for rle_param_enc. Two encoders (1-byte and 2-byte count fields)
// each own a behavioural word memory. Directed messages are loaded into
// memory, a frame is run, and the produced words, rle_size and write count
// are compared against hand-computed values.
module tb_rle_param_enc;

  localparam int MSG_WORD = 64;   // byte address 0x100
  localparam int OUT_WORD = 512;  // byte address 0x800

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start2;
  logic [31:0] message_addr, message_size, rle_addr;

  logic [31:0] rle_size1, rle_size2;
  logic        done1, done2, pclk1, pclk2, we1, we2;
  logic [15:0] addr1, addr2;
  logic [31:0] din1, din2, dout1, dout2;

  logic [31:0] mem1 [0:1023];
  logic [31:0] mem2 [0:1023];

  logic        tb_we;
  int          tb_sel;
  logic [9:0]  tb_addr;
  logic [31:0] tb_data;

  int wr_cnt1 = 0;
  int wr_cnt2 = 0;
  int checks  = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  rle_param_enc #(.CNT_BYTES(1), .ADDR_W(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .message_addr(message_addr), .message_size(message_size), .rle_addr(rle_addr),
    .rle_size(rle_size1), .done(done1), .port_A_clk(pclk1), .port_A_addr(addr1),
    .port_A_we(we1), .port_A_data_in(din1), .port_A_data_out(dout1)
  );

  rle_param_enc #(.CNT_BYTES(2), .ADDR_W(16)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .message_addr(message_addr), .message_size(message_size), .rle_addr(rle_addr),
    .rle_size(rle_size2), .done(done2), .port_A_clk(pclk2), .port_A_addr(addr2),
    .port_A_we(we2), .port_A_data_in(din2), .port_A_data_out(dout2)
  );

  // Synchronous single-port memories with one cycle read latency; the bench
  // preloads them through its own write port while the encoders are idle.
  always @(posedge clk) begin
    if (tb_we && tb_sel == 1) mem1[tb_addr] <= tb_data;
    else if (we1) mem1[addr1[11:2]] <= din1;
    dout1 <= mem1[addr1[11:2]];
    if (we1) wr_cnt1 <= wr_cnt1 + 1;
  end

  always @(posedge clk) begin
    if (tb_we && tb_sel == 2) mem2[tb_addr] <= tb_data;
    else if (we2) mem2[addr2[11:2]] <= din2;
    dout2 <= mem2[addr2[11:2]];
    if (we2) wr_cnt2 <= wr_cnt2 + 1;
  end

  typedef struct {
    int          sel;
    int          pat;
    int          size;
    int          max_cyc;
    int          exp_size;
    int          exp_nw;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [7:0] pat_byte(input int pat, input int i, input int size);
    if (i >= size) return 8'h99;
    case (pat)
      0: return (i < 8) ? 8'h41 : 8'h42;
      1: return 8'h00;
      2: return 8'h7A;
      3: return (i < 2) ? 8'hAB : 8'hCD;
      4: return 8'h05;
      default: return (i % 2 == 0) ? 8'h11 : 8'h22;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 1) ? done1 : done2;
  endfunction

  function automatic logic [31:0] get_size(input int sel);
    return (sel == 1) ? rle_size1 : rle_size2;
  endfunction

  function automatic int get_wr(input int sel);
    return (sel == 1) ? wr_cnt1 : wr_cnt2;
  endfunction

  function automatic logic [31:0] get_word(input int sel, input int idx);
    return (sel == 1) ? mem1[idx] : mem2[idx];
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_word(input int sel, input int idx, input logic [31:0] w);
    @(negedge clk);
    tb_we   = 1'b1;
    tb_sel  = sel;
    tb_addr = idx[9:0];
    tb_data = w;
  endtask

  // Load message words (bytes past size filled with 99) and poison the
  // output area so unwritten or extra words are visible.
  task automatic load_msg(input int sel, input int pat, input int size);
    logic [31:0] w;
    for (int k = 0; k < (size + 3) / 4; k++) begin
      for (int b = 0; b < 4; b++) w[8*b +: 8] = pat_byte(pat, 4*k + b, size);
      write_word(sel, MSG_WORD + k, w);
    end
    for (int k = 0; k < 32; k++) write_word(sel, OUT_WORD + k, 32'hDEADBEEF);
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Start a frame (leaving DONE first if needed) and wait, bounded, for done.
  task automatic apply_stimulus(input int sel, input int size, input int max_cyc,
                                output bit ok);
    int cyc;
    message_addr = 32'h0000_0103;
    rle_addr     = 32'h0000_0802;
    message_size = size;
    if (get_done(sel)) pulse_start(sel);
    pulse_start(sel);
    cyc = 1;
    while (!get_done(sel) && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    ok = get_done(sel);
  endtask

  initial begin
    bit ok;
    int wr0;
    logic [31:0] exp;

    vecs[0] = '{1, 0, 12,  40,   4, 1, 32'h04420841, 32'h0};
    vecs[1] = '{1, 1, 300, 3000, 4, 1, 32'h2D00FF00, 32'h0};
    vecs[2] = '{2, 1, 300, 3000, 3, 1, 32'h00012C00, 32'h0};
    vecs[3] = '{1, 2, 1,   100,  2, 1, 32'h0000017A, 32'h0};
    vecs[4] = '{2, 3, 4,   100,  6, 2, 32'hCD0002AB, 32'h00000002};
    vecs[5] = '{1, 4, 256, 3000, 4, 1, 32'h0105FF05, 32'h0};
    vecs[6] = '{1, 4, 255, 3000, 2, 1, 32'h0000FF05, 32'h0};

    reset = 1'b1; start1 = 1'b0; start2 = 1'b0; tb_we = 1'b0;
    tb_sel = 0; tb_addr = '0; tb_data = '0;
    message_addr = '0; message_size = '0; rle_addr = '0;
    repeat (3) @(negedge clk);
    check_output("rst_done1", 32'(done1), 32'd0);
    check_output("rst_size1", rle_size1, 32'd0);
    check_output("rst_we1", 32'(we1), 32'd0);
    check_output("rst_addr1", 32'(addr1), 32'd0);
    check_output("rst_din1", din1, 32'd0);
    check_output("rst_done2", 32'(done2), 32'd0);
    check_output("rst_size2", rle_size2, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      load_msg(vecs[v].sel, vecs[v].pat, vecs[v].size);
      wr0 = get_wr(vecs[v].sel);
      apply_stimulus(vecs[v].sel, vecs[v].size, vecs[v].max_cyc, ok);
      check_output($sformatf("v%0d_done", v), 32'(ok), 32'd1);
      check_output($sformatf("v%0d_size", v), get_size(vecs[v].sel), vecs[v].exp_size);
      check_output($sformatf("v%0d_writes", v), get_wr(vecs[v].sel) - wr0, vecs[v].exp_nw);
      check_output($sformatf("v%0d_w0", v), get_word(vecs[v].sel, OUT_WORD), vecs[v].exp_w0);
      if (vecs[v].exp_nw > 1)
        check_output($sformatf("v%0d_w1", v), get_word(vecs[v].sel, OUT_WORD + 1), vecs[v].exp_w1);
      check_output($sformatf("v%0d_tail", v),
                   get_word(vecs[v].sel, OUT_WORD + vecs[v].exp_nw), 32'hDEADBEEF);
    end

    // Alternating 11/22 with a stray 99 in the unused lane of the last word.
    load_msg(1, 5, 51);
    wr0 = wr_cnt1;
    apply_stimulus(1, 51, 3000, ok);
    check_output("alt_done", 32'(ok), 32'd1);
    check_output("alt_size", rle_size1, 32'd102);
    check_output("alt_writes", wr_cnt1 - wr0, 32'd26);
    for (int k = 0; k < 26; k++) begin
      exp = (k < 25) ? 32'h01220111 : 32'h00000111;
      check_output($sformatf("alt_w%0d", k), mem1[OUT_WORD + k], exp);
    end
    check_output("alt_tail", mem1[OUT_WORD + 26], 32'hDEADBEEF);

    // Empty message: done one cycle after acceptance, nothing written.
    wr0 = wr_cnt1;
    message_size = 32'd0;
    if (done1) pulse_start(1);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check_output("empty_done_low", 32'(done1), 32'd0);
    check_output("empty_size", rle_size1, 32'd0);
    @(negedge clk);
    check_output("empty_done_high", 32'(done1), 32'd1);
    repeat (3) @(negedge clk);
    check_output("empty_writes", wr_cnt1 - wr0, 32'd0);

    // Abort mid-frame with reset, then a clean frame must still be correct.
    load_msg(1, 5, 51);
    message_size = 32'd51;
    pulse_start(1);
    pulse_start(1);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("abort_done", 32'(done1), 32'd0);
    check_output("abort_size", rle_size1, 32'd0);
    check_output("abort_we", 32'(we1), 32'd0);
    check_output("abort_addr", 32'(addr1), 32'd0);
    check_output("abort_din", din1, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    load_msg(1, 0, 12);
    wr0 = wr_cnt1;
    apply_stimulus(1, 12, 40, ok);
    check_output("rerun_done", 32'(ok), 32'd1);
    check_output("rerun_size", rle_size1, 32'd4);
    check_output("rerun_writes", wr_cnt1 - wr0, 32'd1);
    check_output("rerun_w0", mem1[OUT_WORD], 32'h04420841);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
